dmem_ace_slave: RTL and testbench

Single-port on-chip data memory that terminates the LSU's ACE master port. It accepts single-beat read and write transactions on the AR/AW/W channels, performs them against a synchronous byte-writable SRAM array, and returns R/B responses. It sits directly downstream of the LSU (`lsu_ace_if`) and replaces the lower-level memory hierarchy in bring-up and unit-level configurations.

---
 rtl/dmem_ace_slave_if.sv | 101 ++++++++++
 rtl/dmem_ace_slave.sv | 170 +++++++++++++++++
 tb/tb_dmem_ace_slave.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_ace_slave_if.sv
// ACE link between the LSU (master) and a memory-side slave.
// Carries AW/W/B/AR/R plus the AC/CR/CD snoop channels and rack/wack.
interface ace_if #(
   parameter int ACE_AXADDR_WIDTH = 32,
   parameter int ACE_XDATA_WIDTH  = 32,
   parameter int ACE_ID_WIDTH     = 4
);
   logic [ACE_ID_WIDTH-1:0]        awid;
   logic [ACE_AXADDR_WIDTH-1:0]    awaddr;
   logic [7:0]                     awlen;
   logic [2:0]                     awsize;
   logic [1:0]                     awburst;
   logic [2:0]                     awprot;
   logic                           awvalid;
   logic                           awready;

   logic [ACE_XDATA_WIDTH-1:0]     wdata;
   logic [ACE_XDATA_WIDTH/8-1:0]   wstrb;
   logic                           wlast;
   logic                           wvalid;
   logic                           wready;

   logic [ACE_ID_WIDTH-1:0]        bid;
   logic [1:0]                     bresp;
   logic                           bvalid;
   logic                           bready;

   logic [ACE_ID_WIDTH-1:0]        arid;
   logic [ACE_AXADDR_WIDTH-1:0]    araddr;
   logic [7:0]                     arlen;
   logic [2:0]                     arsize;
   logic [1:0]                     arburst;
   logic [2:0]                     arprot;
   logic                           arvalid;
   logic                           arready;

   logic [ACE_ID_WIDTH-1:0]        rid;
   logic [ACE_XDATA_WIDTH-1:0]     rdata;
   logic [1:0]                     rresp;
   logic                           rlast;
   logic                           rvalid;
   logic                           rready;

   logic                           acvalid;
   logic                           acready;
   logic [ACE_AXADDR_WIDTH-1:0]    acaddr;
   logic [3:0]                     acsnoop;
   logic [2:0]                     acprot;

   logic                           crvalid;
   logic                           crready;
   logic [4:0]                     crresp;

   logic                           cdvalid;
   logic                           cdready;
   logic [ACE_XDATA_WIDTH-1:0]     cddata;
   logic                           cdlast;

   logic                           rack;
   logic                           wack;

   modport s (
      input  awid, awaddr, awlen, awsize, awburst, awprot, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready,
      input  arid, araddr, arlen, arsize, arburst, arprot, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready,
      output acvalid, acaddr, acsnoop, acprot,
      input  acready,
      input  crvalid, crresp,
      output crready,
      input  cdvalid, cddata, cdlast,
      output cdready,
      input  rack, wack
   );

   modport m (
      output awid, awaddr, awlen, awsize, awburst, awprot, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready,
      output arid, araddr, arlen, arsize, arburst, arprot, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready,
      input  acvalid, acaddr, acsnoop, acprot,
      output acready,
      output crvalid, crresp,
      input  crready,
      output cdvalid, cddata, cdlast,
      input  cdready,
      output rack, wack
   );
endinterface

// File: rtl/dmem_ace_slave.sv
// Single-beat ACE slave in front of a byte-writable synchronous SRAM.
// Optional feature macro: DMEM_RANGE_CHECK_EN (out-of-window accesses get
// DECERR, writes are dropped, reads return zero). Without it, addresses
// alias modulo the array size and every response is OKAY.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for AW (preferred) or AR
// S_WDATA | AW taken, wready high, waiting for the W beat
// S_BRESP | write done, bvalid high until bready
// S_RDATA | read data registered, rvalid high until rready
module dmem_ace_slave #(
   parameter int          DEPTH     = 1024,
   parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
   input logic clk,
   input logic rst,
   ace_if.s    mem_ace_if
);
   localparam int ADDR_WIDTH = mem_ace_if.ACE_AXADDR_WIDTH;
   localparam int DATA_WIDTH = mem_ace_if.ACE_XDATA_WIDTH;
   localparam int IDW        = mem_ace_if.ACE_ID_WIDTH;
   localparam int NBYTES     = DATA_WIDTH / 8;
   localparam int OFS        = $clog2(NBYTES);
   localparam int IDXW       = $clog2(DEPTH);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_WDATA, S_BRESP, S_RDATA} state_t;

   state_t                 state_q;
   logic [IDXW-1:0]        widx_q;
   logic                   werr_q;
   logic                   wready_q;
   logic                   bvalid_q;
   logic [IDW-1:0]         bid_q;
   logic [1:0]             bresp_q;
   logic                   rvalid_q;
   logic                   rlast_q;
   logic [IDW-1:0]         rid_q;
   logic [1:0]             rresp_q;
   logic                   rd_ok_q;
   logic [DATA_WIDTH-1:0]  rd_word_q;
   logic [DATA_WIDTH-1:0]  mem_q [DEPTH];

   logic aw_acc, ar_acc, mem_we, mem_re;
   logic aw_in_range, ar_in_range;

`ifdef DMEM_RANGE_CHECK_EN
   localparam logic [ADDR_WIDTH:0] RANGE_LO = (ADDR_WIDTH+1)'(BASE_ADDR);
   localparam logic [ADDR_WIDTH:0] RANGE_HI =
      (ADDR_WIDTH+1)'(BASE_ADDR + 64'(DEPTH) * 64'(NBYTES));

   assign aw_in_range = ({1'b0, mem_ace_if.awaddr} >= RANGE_LO) &&
                        ({1'b0, mem_ace_if.awaddr} <  RANGE_HI);
   assign ar_in_range = ({1'b0, mem_ace_if.araddr} >= RANGE_LO) &&
                        ({1'b0, mem_ace_if.araddr} <  RANGE_HI);
`else
   assign aw_in_range = 1'b1;
   assign ar_in_range = 1'b1;
`endif

   // Address acceptance is decided from state alone; held low while in reset
   // so both readies show their reset value even if a valid is pending.
   assign aw_acc = rst && (state_q == S_IDLE) && mem_ace_if.awvalid;
   assign ar_acc = rst && (state_q == S_IDLE) && !mem_ace_if.awvalid &&
                   mem_ace_if.arvalid;
   assign mem_we = (state_q == S_WDATA) && mem_ace_if.wvalid && !werr_q;
   assign mem_re = ar_acc && ar_in_range;

   // SRAM array: synchronous read at AR acceptance, byte-masked write on W.
   always_ff @(posedge clk) begin
      if (mem_re) rd_word_q <= mem_q[mem_ace_if.araddr[OFS +: IDXW]];
      for (int b = 0; b < NBYTES; b++) begin
         if (mem_we && mem_ace_if.wstrb[b])
            mem_q[widx_q][b*8 +: 8] <= mem_ace_if.wdata[b*8 +: 8];
      end
   end

   // Transaction FSM with registered channel outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         widx_q   <= '0;
         werr_q   <= 1'b0;
         wready_q <= 1'b0;
         bvalid_q <= 1'b0;
         bid_q    <= '0;
         bresp_q  <= RESP_OKAY;
         rvalid_q <= 1'b0;
         rlast_q  <= 1'b0;
         rid_q    <= '0;
         rresp_q  <= RESP_OKAY;
         rd_ok_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (aw_acc) begin
                  widx_q   <= mem_ace_if.awaddr[OFS +: IDXW];
                  werr_q   <= !aw_in_range;
                  bid_q    <= mem_ace_if.awid;
                  wready_q <= 1'b1;
                  state_q  <= S_WDATA;
               end else if (ar_acc) begin
                  rid_q    <= mem_ace_if.arid;
                  rd_ok_q  <= ar_in_range;
                  rresp_q  <= ar_in_range ? RESP_OKAY : RESP_DECERR;
                  rvalid_q <= 1'b1;
                  rlast_q  <= 1'b1;
                  state_q  <= S_RDATA;
               end
            end
            S_WDATA: begin
               if (mem_ace_if.wvalid) begin
                  wready_q <= 1'b0;
                  bvalid_q <= 1'b1;
                  bresp_q  <= werr_q ? RESP_DECERR : RESP_OKAY;
                  state_q  <= S_BRESP;
               end
            end
            S_BRESP: begin
               if (mem_ace_if.bready) begin
                  bvalid_q <= 1'b0;
                  state_q  <= S_IDLE;
               end
            end
            S_RDATA: begin
               if (mem_ace_if.rready) begin
                  rvalid_q <= 1'b0;
                  rlast_q  <= 1'b0;
                  state_q  <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign mem_ace_if.awready = aw_acc;
   assign mem_ace_if.arready = ar_acc;
   assign mem_ace_if.wready  = wready_q;
   assign mem_ace_if.bvalid  = bvalid_q;
   assign mem_ace_if.bid     = bid_q;
   assign mem_ace_if.bresp   = bresp_q;
   assign mem_ace_if.rvalid  = rvalid_q;
   assign mem_ace_if.rlast   = rlast_q;
   assign mem_ace_if.rid     = rid_q;
   assign mem_ace_if.rresp   = rresp_q;
   // rd_ok_q masks the uninitialised read register after reset and zeroes
   // out-of-range reads.
   assign mem_ace_if.rdata   = rd_ok_q ? rd_word_q : '0;

   assign mem_ace_if.acvalid = 1'b0;
   assign mem_ace_if.acaddr  = '0;
   assign mem_ace_if.acsnoop = '0;
   assign mem_ace_if.acprot  = '0;
   assign mem_ace_if.crready = 1'b1;
   assign mem_ace_if.cdready = 1'b1;

   // Fields this slave deliberately ignores.
   logic unused_ok;
   assign unused_ok = ^{mem_ace_if.awlen, mem_ace_if.awsize, mem_ace_if.awburst,
                        mem_ace_if.awprot, mem_ace_if.arlen, mem_ace_if.arsize,
                        mem_ace_if.arburst, mem_ace_if.arprot, mem_ace_if.wlast,
                        mem_ace_if.rack, mem_ace_if.wack, mem_ace_if.acready,
                        mem_ace_if.crvalid, mem_ace_if.crresp, mem_ace_if.cdvalid,
                        mem_ace_if.cddata, mem_ace_if.cdlast, mem_ace_if.awaddr,
                        mem_ace_if.araddr};
endmodule

// File: tb/tb_dmem_ace_slave.sv
// Randomised bench for dmem_ace_slave against a word-array reference model.
module tb_dmem_ace_slave;
   localparam int          DEPTH = 16;
   localparam logic [31:0] BASE  = 32'h8000_0000;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;
   logic [31:0] model [DEPTH];

   ace_if #(.ACE_AXADDR_WIDTH(32), .ACE_XDATA_WIDTH(32), .ACE_ID_WIDTH(4)) bus ();

   dmem_ace_slave #(.DEPTH(DEPTH), .BASE_ADDR(64'h8000_0000)) dut (
      .clk        (clk),
      .rst        (rst),
      .mem_ace_if (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   // Word index the address should reach, or -1 if it must be rejected.
   function automatic int widx(input logic [31:0] a);
`ifdef DMEM_RANGE_CHECK_EN
      logic [31:0] off;
      if (a < BASE) return -1;
      off = a - BASE;
      if (off >= DEPTH * 4) return -1;
      return int'(off / 4);
`else
      return int'((a / 4) % DEPTH);
`endif
   endfunction

   task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [3:0] id, input int bdly);
      int i;
      int n;
      bus.awvalid = 1'b1; bus.awaddr = a; bus.awid = id;
      #1;
      n = 0;
      while (!bus.awready && n < 20) begin @(negedge clk); #1; n++; end
      chk("awready", bus.awready, 1);
      @(negedge clk);
      bus.awvalid = 1'b0; bus.awaddr = $urandom;
      chk("wready", bus.wready, 1);
      chk("bvalid_early", bus.bvalid, 0);
      bus.wvalid = 1'b1; bus.wdata = d; bus.wstrb = s; bus.wlast = 1'b1;
      @(negedge clk);
      bus.wvalid = 1'b0; bus.wdata = $urandom;
      i = widx(a);
      if (i >= 0)
         for (int b = 0; b < 4; b++) if (s[b]) model[i][b*8 +: 8] = d[b*8 +: 8];
      chk("wready_drop", bus.wready, 0);
      chk("bvalid", bus.bvalid, 1);
      chk("bid", bus.bid, id);
      chk("bresp", bus.bresp, (i >= 0) ? 32'd0 : 32'd3);
      for (int k = 0; k < bdly; k++) begin
         @(negedge clk);
         chk("bvalid_hold", bus.bvalid, 1);
         chk("bid_hold", bus.bid, id);
      end
      bus.bready = 1'b1;
      @(negedge clk);
      bus.bready = 1'b0;
      chk("bvalid_clr", bus.bvalid, 0);
   endtask

   task automatic do_read(input logic [31:0] a, input logic [3:0] id, input int rdly);
      int i;
      int n;
      logic [31:0] exp_d;
      bus.arvalid = 1'b1; bus.araddr = a; bus.arid = id;
      #1;
      n = 0;
      while (!bus.arready && n < 20) begin @(negedge clk); #1; n++; end
      chk("arready", bus.arready, 1);
      @(negedge clk);
      bus.arvalid = 1'b0; bus.araddr = $urandom;
      i = widx(a);
      exp_d = (i >= 0) ? model[i] : 32'd0;
      chk("rvalid", bus.rvalid, 1);
      chk("rdata", bus.rdata, exp_d);
      chk("rid", bus.rid, id);
      chk("rresp", bus.rresp, (i >= 0) ? 32'd0 : 32'd3);
      chk("rlast", bus.rlast, 1);
      for (int k = 0; k < rdly; k++) begin
         @(negedge clk);
         chk("rvalid_hold", bus.rvalid, 1);
         chk("rdata_hold", bus.rdata, exp_d);
         chk("rid_hold", bus.rid, id);
      end
      bus.rready = 1'b1;
      @(negedge clk);
      bus.rready = 1'b0;
      chk("rvalid_clr", bus.rvalid, 0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_awready"}, bus.awready, 0);
      chk({tag, "_wready"},  bus.wready,  0);
      chk({tag, "_bvalid"},  bus.bvalid,  0);
      chk({tag, "_arready"}, bus.arready, 0);
      chk({tag, "_rvalid"},  bus.rvalid,  0);
      chk({tag, "_rlast"},   bus.rlast,   0);
      chk({tag, "_bid"},     bus.bid,     0);
      chk({tag, "_bresp"},   bus.bresp,   0);
      chk({tag, "_rid"},     bus.rid,     0);
      chk({tag, "_rresp"},   bus.rresp,   0);
      chk({tag, "_rdata"},   bus.rdata,   0);
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] d;
      bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = 3'd2;
      bus.awburst = 2'b01; bus.awprot = '0; bus.awvalid = 1'b0;
      bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
      bus.bready = 1'b0;
      bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = 3'd2;
      bus.arburst = 2'b01; bus.arprot = '0; bus.arvalid = 1'b0;
      bus.rready = 1'b0;
      bus.acready = 1'b1; bus.crvalid = 1'b0; bus.crresp = '0;
      bus.cdvalid = 1'b0; bus.cddata = '0; bus.cdlast = 1'b0;
      bus.rack = 1'b0; bus.wack = 1'b0;

      repeat (3) @(negedge clk);
      chk_reset_outputs("rst");
      chk("acvalid", bus.acvalid, 0);
      chk("acaddr", bus.acaddr, 0);
      chk("crready", bus.crready, 1);
      chk("cdready", bus.cdready, 1);
      rst = 1'b1;
      @(negedge clk);

      // Fill every word so later reads are fully defined.
      for (int i = 0; i < DEPTH; i++) do_write(BASE + 32'(i) * 4, $urandom, 4'hF, 4'(i), 0);

      // Basic write/read, then partial strobe on the same word.
      do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 4'h3, 0);
      do_read (32'h8000_0010, 4'h9, 0);
      do_write(32'h8000_0010, 32'h0000_1234, 4'h3, 4'h5, 1);
      do_read (32'h8000_0010, 4'hA, 0);
      chk("partial_word", model[4], 32'hDEAD_1234);

      // Simultaneous AW and AR to the same word: write first, read sees it.
      a = 32'h8000_0020; d = 32'hCAFE_F00D;
      bus.awvalid = 1'b1; bus.awaddr = a; bus.awid = 4'h6;
      bus.arvalid = 1'b1; bus.araddr = a; bus.arid = 4'hC;
      #1;
      chk("sim_awready", bus.awready, 1);
      chk("sim_arready", bus.arready, 0);
      @(negedge clk);
      bus.awvalid = 1'b0;
      chk("sim_arready_w", bus.arready, 0);
      chk("sim_wready", bus.wready, 1);
      bus.wvalid = 1'b1; bus.wdata = d; bus.wstrb = 4'hF;
      @(negedge clk);
      bus.wvalid = 1'b0;
      model[widx(a)] = d;
      chk("sim_bvalid", bus.bvalid, 1);
      chk("sim_bid", bus.bid, 4'h6);
      bus.awvalid = 1'b1; bus.awaddr = BASE;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("bp_bvalid", bus.bvalid, 1);
         chk("bp_arready", bus.arready, 0);
         chk("bp_awready", bus.awready, 0);
      end
      bus.awvalid = 1'b0;
      bus.bready = 1'b1;
      @(negedge clk);
      bus.bready = 1'b0;
      #1;
      chk("sim_arready_b", bus.arready, 1);
      @(negedge clk);
      bus.arvalid = 1'b0;
      chk("sim_rvalid", bus.rvalid, 1);
      chk("sim_rdata", bus.rdata, model[widx(a)]);
      chk("sim_rid", bus.rid, 4'hC);
      bus.rready = 1'b1;
      @(negedge clk);
      bus.rready = 1'b0;

      // Read backpressure for 3 cycles.
      do_read(a, 4'h7, 3);

      // Range window edges and the 0x0 alias/DECERR case.
      do_write(32'h0000_0000, 32'h5A5A_5A5A, 4'hF, 4'h2, 0);
      do_read (BASE, 4'h1, 0);
      do_read (32'h0000_0000, 4'h2, 0);
      do_read (BASE + DEPTH * 4 - 4, 4'h3, 0);
      do_read (BASE + DEPTH * 4, 4'h4, 0);
      do_read (BASE - 4, 4'h5, 0);

      // Reset after AW, before W: outputs clear at once, word untouched.
      a = 32'h8000_0030;
      bus.awvalid = 1'b1; bus.awaddr = a; bus.awid = 4'hB;
      #1;
      chk("mid_awready", bus.awready, 1);
      @(negedge clk);
      bus.awvalid = 1'b0;
      chk("mid_wready", bus.wready, 1);
      rst = 1'b0;
      #1;
      chk_reset_outputs("mid");
      bus.wvalid = 1'b1; bus.wdata = 32'hBAD0_BAD0; bus.wstrb = 4'hF;
      repeat (2) @(negedge clk);
      bus.wvalid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      do_read(a, 4'hD, 0);

      // Random traffic.
      for (int t = 0; t < 300; t++) begin
         if ($urandom_range(0, 4) == 0) a = $urandom;
         else a = BASE + 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1)
            do_write(a, $urandom, 4'($urandom), 4'($urandom), $urandom_range(0, 2));
         else
            do_read(a, 4'($urandom), $urandom_range(0, 2));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
